// File: rtl/hex_pkg.sv
// Shared definitions for the 7-segment display controller: register map,
// segment type and the active-low glyph table (bit 6 = seg a ... bit 0 = seg g).
package hex_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_ENABLE = 2'd1;
    localparam logic [1:0] ADDR_BLINK  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t SEG_0 = 7'b0000001;
    localparam seg_t SEG_1 = 7'b1001111;
    localparam seg_t SEG_2 = 7'b0010010;
    localparam seg_t SEG_3 = 7'b0000110;
    localparam seg_t SEG_4 = 7'b1001100;
    localparam seg_t SEG_5 = 7'b0100100;
    localparam seg_t SEG_6 = 7'b0100000;
    localparam seg_t SEG_7 = 7'b0001111;
    localparam seg_t SEG_8 = 7'b0000000;
    localparam seg_t SEG_9 = 7'b0000100;
    localparam seg_t SEG_A = 7'b0001000;
    localparam seg_t SEG_B = 7'b1100000;
    localparam seg_t SEG_C = 7'b0110001;
    localparam seg_t SEG_D = 7'b1000010;
    localparam seg_t SEG_E = 7'b0110000;
    localparam seg_t SEG_F = 7'b0111000;

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational nibble to active-low 7-segment decoder covering 0-F.
module hex_seg_decoder
    import hex_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Bus-mapped multi-digit 7-segment controller with blanking, optional blinking
// (enabled by defining HEX_BLINK_EN) and registered read-back.
module hex_display_ctrl
    import hex_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                      iClk,
    input  logic                      iReset_n,
    input  logic                      iChip_select_n,
    input  logic                      iWrite_n,
    input  logic                      iRead_n,
    input  logic [1:0]                iAddress,
    input  logic [31:0]               iWrite_data,
    output logic [31:0]               oRead_data,
    output logic [7*NUM_DIGITS-1:0]   oHEX
);

    localparam int DW = 4 * NUM_DIGITS;

    logic                    w_wr;
    logic                    w_rd;
    logic [DW-1:0]           r_data;
    logic [NUM_DIGITS-1:0]   r_enable;
    logic [NUM_DIGITS-1:0]   w_blink_rd;
    logic [NUM_DIGITS-1:0]   w_blink_hide;
    logic                    w_phase;
    logic [31:0]             w_rd_value;
    logic [31:0]             r_read_data;
    seg_t                    w_seg [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] w_hex_next;
    logic [7*NUM_DIGITS-1:0] r_hex;
    logic                    w_unused;

    assign w_wr = !iChip_select_n && !iWrite_n;
    assign w_rd = !iChip_select_n && !iRead_n;

    // Write-data bits above the digit range and the divider in non-blink builds go unused.
    assign w_unused = ^{iWrite_data, 1'(BLINK_DIV & 1)};

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            r_data      <= '0;
            r_enable    <= '1;
            r_read_data <= '0;
            r_hex       <= {NUM_DIGITS{SEG_0}};
        end else begin
            if (w_wr) begin
                case (iAddress)
                    ADDR_DATA:   r_data   <= iWrite_data[DW-1:0];
                    ADDR_ENABLE: r_enable <= iWrite_data[NUM_DIGITS-1:0];
                    default:     ;
                endcase
            end
            // Read mux sees pre-write values, so a same-cycle read returns old data.
            if (w_rd) begin
                r_read_data <= w_rd_value;
            end
            r_hex <= w_hex_next;
        end
    end

`ifdef HEX_BLINK_EN
    localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [NUM_DIGITS-1:0] r_blink;
    logic [PW-1:0]         r_presc;
    logic                  r_phase;

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            r_blink <= '0;
            r_presc <= '0;
            r_phase <= 1'b0;
        end else if (w_wr && (iAddress == ADDR_BLINK)) begin
            r_blink <= iWrite_data[NUM_DIGITS-1:0];
            r_presc <= '0;
            r_phase <= 1'b0;
        end else if (r_blink == '0) begin
            r_presc <= '0;
            r_phase <= 1'b0;
        end else if (r_presc == PW'(BLINK_DIV - 1)) begin
            r_presc <= '0;
            r_phase <= !r_phase;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign w_blink_rd   = r_blink;
    assign w_phase      = r_phase;
    assign w_blink_hide = r_phase ? r_blink : '0;
`else
    assign w_blink_rd   = '0;
    assign w_phase      = 1'b0;
    assign w_blink_hide = '0;
`endif

    always_comb begin
        w_rd_value = '0;
        case (iAddress)
            ADDR_DATA:   w_rd_value = 32'(r_data);
            ADDR_ENABLE: w_rd_value = 32'(r_enable);
            ADDR_BLINK:  w_rd_value = 32'(w_blink_rd);
            ADDR_STATUS: w_rd_value = {31'd0, w_phase};
            default:     w_rd_value = '0;
        endcase
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        hex_seg_decoder u_dec (
            .i_nibble (r_data[4*gi +: 4]),
            .o_seg    (w_seg[gi])
        );
        assign w_hex_next[7*gi +: 7] =
            (r_enable[gi] && !w_blink_hide[gi]) ? w_seg[gi] : SEG_BLANK;
    end

    assign oRead_data = r_read_data;
    assign oHEX       = r_hex;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomized scoreboard bench for hex_display_ctrl with a cycle-count based
// reference model; follows HEX_BLINK_EN the same way the design does.
module tb_hex_display_ctrl;

    localparam int ND  = 6;
    localparam int DIV = 4;

    logic              iClk;
    logic              iReset_n;
    logic              iChip_select_n;
    logic              iWrite_n;
    logic              iRead_n;
    logic [1:0]        iAddress;
    logic [31:0]       iWrite_data;
    logic [31:0]       oRead_data;
    logic [7*ND-1:0]   oHEX;

    hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(DIV)) dut (
        .iClk           (iClk),
        .iReset_n       (iReset_n),
        .iChip_select_n (iChip_select_n),
        .iWrite_n       (iWrite_n),
        .iRead_n        (iRead_n),
        .iAddress       (iAddress),
        .iWrite_data    (iWrite_data),
        .oRead_data     (oRead_data),
        .oHEX           (oHEX)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    logic [6:0] ref_seg [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    localparam logic [31:0] DATA_MASK = 32'((64'd1 << (4 * ND)) - 1);

    // Reference state: registers plus edges elapsed since the last BLINK write.
    logic [31:0]     m_data;
    logic [ND-1:0]   m_en;
    logic [ND-1:0]   m_blink;
    int              m_n;
    logic [7*ND-1:0] m_hex;
    bit              m_rd_pending;
    logic [31:0]     sb_q[$];

    int  passed = 0;
    int  total  = 0;
    bit  mon_en = 0;

    function automatic bit mphase(input logic [ND-1:0] b, input int n);
        if (b == '0) return 1'b0;
        return ((n / DIV) % 2) == 1;
    endfunction

    function automatic logic [7*ND-1:0] model_hex(input logic [31:0] d, input logic [ND-1:0] en,
                                                   input logic [ND-1:0] b, input int n);
        logic [7*ND-1:0] r;
        bit ph;
        r  = '0;
        ph = mphase(b, n);
        for (int k = 0; k < ND; k++) begin
            if (en[k] && !(b[k] && ph)) r[7*k +: 7] = ref_seg[d[4*k +: 4]];
            else                        r[7*k +: 7] = 7'h7F;
        end
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_data;
            2'd1:    return 32'(m_en);
            2'd2:    return 32'(m_blink);
            default: return {31'd0, mphase(m_blink, m_n)};
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(posedge iClk) begin
        if (!iReset_n) begin
            m_data       <= '0;
            m_en         <= '1;
            m_blink      <= '0;
            m_n          <= 0;
            m_hex        <= {ND{7'b0000001}};
            m_rd_pending <= 1'b0;
        end else begin
            m_hex        <= model_hex(m_data, m_en, m_blink, m_n);
            m_rd_pending <= !iChip_select_n && !iRead_n;
            if (!iChip_select_n && !iRead_n) sb_q.push_back(model_read(iAddress));
            m_n <= m_n + 1;
            if (!iChip_select_n && !iWrite_n) begin
                case (iAddress)
                    2'd0: m_data <= iWrite_data & DATA_MASK;
                    2'd1: m_en   <= iWrite_data[ND-1:0];
`ifdef HEX_BLINK_EN
                    2'd2: begin
                        m_blink <= iWrite_data[ND-1:0];
                        m_n     <= 0;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // Monitor: segments every cycle, read data whenever a read was sampled.
    always @(negedge iClk) begin
        if (mon_en) begin
            check("hex", 64'(oHEX), 64'(m_hex));
            if (m_rd_pending) begin
                if (sb_q.size() == 0) begin
                    check("rd_queue_nonempty", 64'd0, 64'd1);
                end else begin
                    logic [31:0] e;
                    e = sb_q.pop_front();
                    check("rdata", 64'(oRead_data), 64'(e));
                    $display("read  got=%h exp=%h", oRead_data, e);
                end
            end
        end
    end

    task automatic xfer(input bit w, input bit r, input logic [1:0] a, input logic [31:0] d);
        @(negedge iClk);
        iChip_select_n = 1'b0;
        iWrite_n       = !w;
        iRead_n        = !r;
        iAddress       = a;
        iWrite_data    = d;
        $display("xfer  w=%0d r=%0d addr=%0d data=%h", w, r, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge iClk);
            iChip_select_n = 1'b1;
            iWrite_n       = 1'b1;
            iRead_n        = 1'b1;
        end
    endtask

    initial begin
        iReset_n = 1'b0;
        iChip_select_n = 1'b1;
        iWrite_n = 1'b1;
        iRead_n = 1'b1;
        iAddress = 2'd0;
        iWrite_data = '0;
        repeat (3) @(negedge iClk);
        mon_en = 1'b1;
        iReset_n = 1'b1;
        check("rst_rdata", 64'(oRead_data), 64'd0);
        check("rst_hex", 64'(oHEX), 64'({ND{7'b0000001}}));

        xfer(0, 1, 2'd1, 32'd0);
        xfer(1, 0, 2'd0, 32'h00FEDCBA);
        idle(2);
        check("abcdef_hex", 64'(oHEX),
              64'({7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001, 7'b1100000, 7'b0001000}));
        xfer(0, 1, 2'd0, 32'd0);
        xfer(1, 0, 2'd0, 32'hFFFFFFFF);
        xfer(0, 1, 2'd0, 32'd0);
        xfer(1, 0, 2'd1, 32'h05);
        idle(3);

`ifdef HEX_BLINK_EN
        xfer(1, 0, 2'd2, 32'h01);
        repeat (14) xfer(0, 1, 2'd3, 32'd0);
        idle(2);
`else
        xfer(1, 1, 2'd2, 32'h01);
        xfer(0, 1, 2'd2, 32'd0);
        idle(10);
`endif

        xfer(1, 0, 2'd0, 32'h1);
        xfer(1, 1, 2'd0, 32'h2);
        xfer(0, 1, 2'd0, 32'd0);
        idle(1);

`ifdef HEX_BLINK_EN
        xfer(1, 0, 2'd2, 32'h3F);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                idle(1);
                seen = mphase(m_blink, m_n);
            end
            check("blank_phase_reached", 64'(seen), 64'd1);
        end
`endif
        @(negedge iClk);
        iReset_n = 1'b0;
        @(negedge iClk);
        iReset_n = 1'b1;
        check("rst_mid_hex", 64'(oHEX), 64'({ND{7'b0000001}}));
        check("rst_mid_rdata", 64'(oRead_data), 64'd0);
        xfer(0, 1, 2'd3, 32'd0);
        xfer(0, 1, 2'd2, 32'd0);
        idle(1);

        for (int i = 0; i < 400; i++) begin
            logic [1:0]  a;
            logic [31:0] d;
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if (a == 2'd2 && ($urandom % 2) == 0) d = 32'(d[ND-1:0] & 6'h0F);
            xfer(bit'($urandom % 2), bit'($urandom % 2), a, d);
            if (($urandom % 4) == 0) idle($urandom_range(1, 9));
        end
        idle(4);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
